// File: rtl/apb_arb_master.sv
// APB master shared by two requesters: round-robin grant, address range check,
// and an ACCESS-phase timeout. All outputs come straight from registers.
module apb_arb_master #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned ADDR_MAX = 123
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [31:0] PRDATA,
    output logic        busy
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_last, w_last_nxt;
    logic [CntW-1:0]  r_tcnt, w_tcnt_nxt;
    logic             r_grant, w_grant_nxt;
    logic             r_write, w_write_nxt;
    logic [31:0]      r_addr, w_addr_nxt;
    logic [31:0]      r_wdata, w_wdata_nxt;

    logic             r_psel, w_psel_nxt;
    logic             r_penable, w_penable_nxt;
    logic             r_pwrite, w_pwrite_nxt;
    logic [31:0]      r_paddr, w_paddr_nxt;
    logic [31:0]      r_pwdata, w_pwdata_nxt;
    logic [1:0]       r_req_ready, w_req_ready_nxt;
    logic [1:0]       r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]      r_rsp_rdata, w_rsp_rdata_nxt;
    logic             r_rsp_err, w_rsp_err_nxt;
    logic             r_busy, w_busy_nxt;

    logic             w_sel;
    logic             w_sel_write;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [1:0]       w_sel_oh;
    logic [1:0]       w_grant_oh;

    // On contention the requester not served last wins; a lone request always wins.
    assign w_sel       = (&req_valid) ? ~r_last : req_valid[1];
    assign w_sel_write = w_sel ? req_write[1] : req_write[0];
    assign w_sel_addr  = w_sel ? req_addr[63:32] : req_addr[31:0];
    assign w_sel_wdata = w_sel ? req_wdata[63:32] : req_wdata[31:0];
    assign w_sel_oh    = w_sel ? 2'b10 : 2'b01;
    assign w_grant_oh  = r_grant ? 2'b10 : 2'b01;

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_tcnt_nxt      = '0;
        w_grant_nxt     = r_grant;
        w_write_nxt     = r_write;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_pwrite_nxt    = 1'b0;
        w_paddr_nxt     = '0;
        w_pwdata_nxt    = '0;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (|req_valid) begin
                    w_grant_nxt     = w_sel;
                    w_last_nxt      = w_sel;
                    w_write_nxt     = w_sel_write;
                    w_addr_nxt      = w_sel_addr;
                    w_wdata_nxt     = w_sel_wdata;
                    w_req_ready_nxt = w_sel_oh;
                    if (w_sel_addr <= 32'(ADDR_MAX)) begin
                        w_state_nxt  = StSetup;
                        w_psel_nxt   = 1'b1;
                        w_pwrite_nxt = w_sel_write;
                        w_paddr_nxt  = w_sel_addr;
                        w_pwdata_nxt = w_sel_wdata;
                    end else begin
                        // Out-of-range address never reaches the bus.
                        w_state_nxt     = StResp;
                        w_rsp_valid_nxt = w_sel_oh;
                        w_rsp_err_nxt   = 1'b1;
                    end
                end
            end
            StSetup: begin
                w_state_nxt   = StAccess;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_pwrite_nxt  = r_write;
                w_paddr_nxt   = r_addr;
                w_pwdata_nxt  = r_wdata;
            end
            StAccess: begin
                if (PREADY) begin
                    w_state_nxt     = StResp;
                    w_rsp_valid_nxt = w_grant_oh;
                    w_rsp_err_nxt   = PSLVERR;
                    w_rsp_rdata_nxt = r_write ? 32'h0 : PRDATA;
                end else if (r_tcnt == CntW'(TIMEOUT - 1)) begin
                    w_state_nxt     = StResp;
                    w_rsp_valid_nxt = w_grant_oh;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_tcnt_nxt    = r_tcnt + 1'b1;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                    w_pwrite_nxt  = r_write;
                    w_paddr_nxt   = r_addr;
                    w_pwdata_nxt  = r_wdata;
                end
            end
            StResp: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        w_busy_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= StIdle;
            r_last      <= 1'b1;
            r_tcnt      <= '0;
            r_grant     <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_grant     <= w_grant_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule
